// File: rtl/nios_cmd_out.sv
// Avalon-MM command output port: software pushes command words into a small FIFO
// that drains to a fabric consumer over a valid/ready handshake.
module nios_cmd_out #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  logic                  r_enable;
  logic [31:0]           r_readdata;

  logic                  w_wr_en;
  logic                  w_push;
  logic                  w_push_ok;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_empty;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_head;
  logic [31:0]           w_status;
  logic [31:0]           w_rd_mux;
  logic                  w_unused;

  assign w_wr_en   = chipselect && !write_n;
  assign w_push    = w_wr_en && (address == 2'd0);
  assign w_flush   = w_wr_en && (address == 2'd2) && writedata[1];
  assign w_ovf_clr = w_wr_en && (address == 2'd1) && writedata[5];

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];

  assign out_valid = r_enable && !w_empty;
  assign out_port  = w_head;
  assign readdata  = r_readdata;

  assign w_pop     = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  assign w_unused  = ^writedata[31:DATA_WIDTH];

  always_comb begin
    w_status         = '0;
    w_status[LW-1:0] = r_level;
    w_status[3]      = w_full;
    w_status[4]      = w_empty;
    w_status[5]      = r_overflow;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux = 32'(w_head);
      2'd1:    w_rd_mux = w_status;
      2'd2:    w_rd_mux = 32'(r_enable);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok && !w_flush) begin
      r_mem[r_wr_ptr] <= writedata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_enable   <= 1'b1;
      r_readdata <= '0;
    end else begin
      // A new overflow beats a same-cycle clear.
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
      if (w_wr_en && (address == 2'd2)) r_enable <= writedata[0];
      r_readdata <= w_rd_mux;
    end
  end

endmodule
